// File: rtl/match_slot_selector_pkg.sv
// Shared types and width helpers for the match slot selector.
// Default storage/search sizing lives here so all users agree on slot widths.
package match_slot_selector_pkg;

  localparam int MAX_STORE_DEF  = 2;
  localparam int ERR_CYCLES_DEF = 100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BROWSE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_EMPTY  = 2'd3
  } state_e;

  function automatic int slot_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/match_slot_selector_ring_next_bit.sv
// Combinational ring search: next set bit strictly above cur_idx_i, wrapping to the lowest.
// With cur_idx_i = N-1 the result is the lowest set bit of the mask.
module ring_next_bit #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] cur_idx_i,
  output logic [IW-1:0] nxt_idx_o
);

  logic [IW-1:0] above_idx;
  logic [IW-1:0] low_idx;
  logic          above_found;

  // Scan high to low so the nearest candidate is the last one written.
  always_comb begin
    above_idx   = '0;
    low_idx     = '0;
    above_found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (mask_i[j]) begin
        low_idx = IW'(j);
        if (j > int'(cur_idx_i)) begin
          above_idx   = IW'(j);
          above_found = 1'b1;
        end
      end
    end
  end

  assign nxt_idx_o = above_found ? above_idx : low_idx;

endmodule

// File: rtl/match_slot_selector.sv
// Match slot selector: snapshot a search mask, let the user browse matches, hand off the choice.
// Optional SINGLE_MATCH_AUTO_EN: a lone match skips browsing and is offered immediately.
//
// state  | meaning
// IDLE   | waiting for start
// BROWSE | user stepping through matches in mask_q
// HOLD   | sel_slot offered, waiting for sel_ready
// EMPTY  | no match found, no_match held for ERR_CYCLES
module match_slot_selector
  import match_slot_selector_pkg::*;
#(
  parameter int  MAX_STORE  = MAX_STORE_DEF,
  parameter int  ERR_CYCLES = ERR_CYCLES_DEF,
  localparam int SLOT_BITS  = slot_bits(MAX_STORE),
  localparam int CNT_BITS   = cnt_bits(MAX_STORE)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [MAX_STORE-1:0] match_mask_i,
  input  logic                 btn_next_i,
  input  logic                 btn_confirm_i,
  input  logic                 btn_cancel_i,
  input  logic                 sel_ready_i,
  output logic                 busy_o,
  output logic                 cur_valid_o,
  output logic [SLOT_BITS-1:0] cur_slot_o,
  output logic [CNT_BITS-1:0]  cur_ord_o,
  output logic                 sel_valid_o,
  output logic [SLOT_BITS-1:0] sel_slot_o,
  output logic                 no_match_o
);

  localparam int                ERR_BITS = cnt_bits(ERR_CYCLES);
  localparam logic [ERR_BITS-1:0] ERR_LOAD = ERR_BITS'(ERR_CYCLES - 1);

  state_e                 state_q;
  logic [MAX_STORE-1:0]   mask_q;
  logic [SLOT_BITS-1:0]   cur_slot_q;
  logic [CNT_BITS-1:0]    cur_ord_q;
  logic [SLOT_BITS-1:0]   sel_slot_q;
  logic                   cur_valid_q;
  logic                   sel_valid_q;
  logic                   no_match_q;
  logic                   busy_q;
  logic [ERR_BITS-1:0]    err_cnt_q;

  logic [SLOT_BITS-1:0]   low_slot;
  logic [SLOT_BITS-1:0]   nxt_slot;

  ring_next_bit #(.N(MAX_STORE), .IW(SLOT_BITS)) u_lowest (
    .mask_i    (match_mask_i),
    .cur_idx_i (SLOT_BITS'(MAX_STORE - 1)),
    .nxt_idx_o (low_slot)
  );

  ring_next_bit #(.N(MAX_STORE), .IW(SLOT_BITS)) u_next (
    .mask_i    (mask_q),
    .cur_idx_i (cur_slot_q),
    .nxt_idx_o (nxt_slot)
  );

`ifdef SINGLE_MATCH_AUTO_EN
  logic mask_single;
  assign mask_single = (match_mask_i != '0) &&
                       ((match_mask_i & (match_mask_i - MAX_STORE'(1))) == '0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      cur_slot_q  <= '0;
      cur_ord_q   <= '0;
      sel_slot_q  <= '0;
      cur_valid_q <= 1'b0;
      sel_valid_q <= 1'b0;
      no_match_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mask_q <= match_mask_i;
            busy_q <= 1'b1;
            if (match_mask_i == '0) begin
              state_q    <= ST_EMPTY;
              no_match_q <= 1'b1;
              err_cnt_q  <= ERR_LOAD;
            end
`ifdef SINGLE_MATCH_AUTO_EN
            else if (mask_single) begin
              state_q     <= ST_HOLD;
              cur_valid_q <= 1'b1;
              cur_slot_q  <= low_slot;
              cur_ord_q   <= CNT_BITS'(1);
              sel_valid_q <= 1'b1;
              sel_slot_q  <= low_slot;
            end
`endif
            else begin
              state_q     <= ST_BROWSE;
              cur_valid_q <= 1'b1;
              cur_slot_q  <= low_slot;
              cur_ord_q   <= CNT_BITS'(1);
            end
          end
        end
        ST_BROWSE: begin
          if (btn_cancel_i) begin
            state_q     <= ST_IDLE;
            cur_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (btn_confirm_i) begin
            state_q     <= ST_HOLD;
            sel_valid_q <= 1'b1;
            sel_slot_q  <= cur_slot_q;
          end else if (btn_next_i) begin
            cur_slot_q <= nxt_slot;
            // Not moving upward means we wrapped (or there is only one match).
            cur_ord_q  <= (nxt_slot <= cur_slot_q) ? CNT_BITS'(1) : cur_ord_q + CNT_BITS'(1);
          end
        end
        ST_HOLD: begin
          if (sel_valid_q && sel_ready_i) begin
            state_q     <= ST_IDLE;
            sel_valid_q <= 1'b0;
            cur_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        ST_EMPTY: begin
          if (err_cnt_q == '0) begin
            state_q    <= ST_IDLE;
            no_match_q <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            err_cnt_q <= err_cnt_q - ERR_BITS'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign cur_valid_o = cur_valid_q;
  assign cur_slot_o  = cur_slot_q;
  assign cur_ord_o   = cur_ord_q;
  assign sel_valid_o = sel_valid_q;
  assign sel_slot_o  = sel_slot_q;
  assign no_match_o  = no_match_q;

endmodule

// File: tb/tb_match_slot_selector.sv
// Scoreboard bench for match_slot_selector (MAX_STORE=4, short error hold).
module tb_match_slot_selector;

  localparam int MS = 4;
  localparam int EC = 5;

  localparam int EV_CUR   = 0;
  localparam int EV_OFFER = 1;
  localparam int EV_SEL   = 2;
  localparam int EV_ERR   = 3;
  localparam int EV_IDLE  = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [MS-1:0] match_mask_i;
  logic          btn_next_i;
  logic          btn_confirm_i;
  logic          btn_cancel_i;
  logic          sel_ready_i;
  logic          busy_o;
  logic          cur_valid_o;
  logic [1:0]    cur_slot_o;
  logic [2:0]    cur_ord_o;
  logic          sel_valid_o;
  logic [1:0]    sel_slot_o;
  logic          no_match_o;

  match_slot_selector #(.MAX_STORE(MS), .ERR_CYCLES(EC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .match_mask_i  (match_mask_i),
    .btn_next_i    (btn_next_i),
    .btn_confirm_i (btn_confirm_i),
    .btn_cancel_i  (btn_cancel_i),
    .sel_ready_i   (sel_ready_i),
    .busy_o        (busy_o),
    .cur_valid_o   (cur_valid_o),
    .cur_slot_o    (cur_slot_o),
    .cur_ord_o     (cur_ord_o),
    .sel_valid_o   (sel_valid_o),
    .sel_slot_o    (sel_slot_o),
    .no_match_o    (no_match_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input int a, input int b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int a, input int b);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual kind=%0d a=%0d b=%0d required=no event", kind, a, b);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_a", a, e.a);
      check("event_b", b, e.b);
    end
  endtask

  // Monitor: turns DUT output activity into events and checks handshake stability.
  logic       p_cv, p_sv, p_busy, p_nm, p_xfer;
  logic [1:0] p_cs, p_ss;
  logic [2:0] p_co;
  int         nm_len;

  always @(negedge clk_i) begin
    if (rst_i) begin
      nm_len = 0;
    end else begin
      if (cur_valid_o && (!p_cv || cur_slot_o != p_cs || cur_ord_o != p_co))
        observe(EV_CUR, int'(cur_slot_o), int'(cur_ord_o));
      if (sel_valid_o && !p_sv)
        observe(EV_OFFER, int'(sel_slot_o), 0);
      if (p_sv && !p_xfer) begin
        check("sel_held_valid", int'(sel_valid_o), 1);
        check("sel_held_slot", int'(sel_slot_o), int'(p_ss));
      end
      if (sel_valid_o && sel_ready_i)
        observe(EV_SEL, int'(sel_slot_o), 0);
      if (no_match_o) begin
        nm_len++;
        check("busy_during_no_match", int'(busy_o), 1);
      end else if (p_nm) begin
        observe(EV_ERR, nm_len, 0);
        nm_len = 0;
      end
      if (p_busy && !busy_o)
        observe(EV_IDLE, 0, 0);
    end
    p_cv   = cur_valid_o;
    p_cs   = cur_slot_o;
    p_co   = cur_ord_o;
    p_sv   = sel_valid_o;
    p_ss   = sel_slot_o;
    p_nm   = no_match_o;
    p_busy = busy_o;
    p_xfer = sel_valid_o && sel_ready_i && !rst_i;
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start(input logic [MS-1:0] m);
    match_mask_i = m;
    start_i      = 1'b1;
    cyc();
    start_i      = 1'b0;
  endtask

  task automatic pulse_btn(input logic n, input logic c, input logic x);
    btn_next_i    = n;
    btn_confirm_i = c;
    btn_cancel_i  = x;
    cyc();
    btn_next_i    = 1'b0;
    btn_confirm_i = 1'b0;
    btn_cancel_i  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (busy_o && i < budget) begin
      cyc();
      i++;
    end
    if (busy_o) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual busy=1 required busy=0 within %0d cycles", budget);
    end
    cyc(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      int'(busy_o), 0);
    check({tag, "_cur_valid"}, int'(cur_valid_o), 0);
    check({tag, "_cur_slot"},  int'(cur_slot_o), 0);
    check({tag, "_cur_ord"},   int'(cur_ord_o), 0);
    check({tag, "_sel_valid"}, int'(sel_valid_o), 0);
    check({tag, "_sel_slot"},  int'(sel_slot_o), 0);
    check({tag, "_no_match"},  int'(no_match_o), 0);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i         = 1'b1;
    start_i       = 1'b0;
    match_mask_i  = '0;
    btn_next_i    = 1'b0;
    btn_confirm_i = 1'b0;
    btn_cancel_i  = 1'b0;
    sel_ready_i   = 1'b0;
    cyc(3);
    @(negedge clk_i);
    check_reset_outputs("reset");
    cyc();
    rst_i = 1'b0;
    cyc(2);

    // Browse two matches with wrap, then cancel.
    expect_ev(EV_CUR, 1, 1);
    expect_ev(EV_CUR, 3, 2);
    expect_ev(EV_CUR, 1, 1);
    expect_ev(EV_IDLE, 0, 0);
    pulse_start(4'b1010);
    cyc();
    pulse_btn(1'b1, 1'b0, 1'b0);
    cyc();
    pulse_btn(1'b1, 1'b0, 1'b0);
    cyc();
    pulse_btn(1'b0, 1'b0, 1'b1);
    wait_idle(10);

    // Single match: next is a no-op, offer held while consumer stalls.
    expect_ev(EV_CUR, 2, 1);
    expect_ev(EV_OFFER, 2, 0);
    pulse_start(4'b0100);
    pulse_btn(1'b1, 1'b0, 1'b0);
    pulse_btn(1'b0, 1'b1, 1'b0);
    cyc(5);
    expect_ev(EV_SEL, 2, 0);
    expect_ev(EV_IDLE, 0, 0);
    sel_ready_i = 1'b1;
    wait_idle(10);
    sel_ready_i = 1'b0;

    // Snapshot: mask change and a second start during browse are ignored.
    expect_ev(EV_CUR, 2, 1);
    expect_ev(EV_CUR, 3, 2);
    expect_ev(EV_CUR, 2, 1);
    expect_ev(EV_CUR, 3, 2);
    expect_ev(EV_IDLE, 0, 0);
    pulse_start(4'b1100);
    match_mask_i = 4'b0001;
    pulse_start(4'b0001);
    pulse_btn(1'b1, 1'b0, 1'b0);
    pulse_btn(1'b1, 1'b0, 1'b0);
    pulse_btn(1'b1, 1'b0, 1'b0);
    pulse_btn(1'b0, 1'b0, 1'b1);
    wait_idle(10);

    // Empty search: no_match for exactly EC cycles, inputs ignored meanwhile.
    expect_ev(EV_ERR, EC, 0);
    expect_ev(EV_IDLE, 0, 0);
    pulse_start(4'b0000);
    pulse_btn(1'b1, 1'b1, 1'b1);
    pulse_start(4'b0010);
    wait_idle(EC + 10);

    // A start after the error hold works normally.
    expect_ev(EV_CUR, 1, 1);
    expect_ev(EV_OFFER, 1, 0);
    expect_ev(EV_SEL, 1, 0);
    expect_ev(EV_IDLE, 0, 0);
    pulse_start(4'b0010);
    pulse_btn(1'b0, 1'b1, 1'b0);
    sel_ready_i = 1'b1;
    wait_idle(10);
    sel_ready_i = 1'b0;

    // Simultaneous buttons: cancel wins, no offer even with ready high.
    expect_ev(EV_CUR, 1, 1);
    expect_ev(EV_IDLE, 0, 0);
    sel_ready_i = 1'b1;
    pulse_start(4'b0110);
    pulse_btn(1'b1, 1'b1, 1'b1);
    wait_idle(10);
    sel_ready_i = 1'b0;

    // Reset while holding an offer.
    expect_ev(EV_CUR, 0, 1);
    expect_ev(EV_OFFER, 0, 0);
    pulse_start(4'b1001);
    pulse_btn(1'b0, 1'b1, 1'b0);
    cyc(2);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("hold_reset");
    cyc();
    rst_i = 1'b0;
    cyc(2);

    // Single high-slot match; auto mode offers it one cycle after start.
    expect_ev(EV_CUR, 3, 1);
    expect_ev(EV_OFFER, 3, 0);
    expect_ev(EV_SEL, 3, 0);
    expect_ev(EV_IDLE, 0, 0);
    pulse_start(4'b1000);
`ifdef SINGLE_MATCH_AUTO_EN
    @(negedge clk_i);
    check("auto_sel_valid", int'(sel_valid_o), 1);
    check("auto_sel_slot", int'(sel_slot_o), 3);
    check("auto_cur_valid", int'(cur_valid_o), 1);
    cyc();
`else
    @(negedge clk_i);
    check("manual_sel_valid", int'(sel_valid_o), 0);
    cyc();
    pulse_btn(1'b0, 1'b1, 1'b0);
`endif
    sel_ready_i = 1'b1;
    wait_idle(10);
    sel_ready_i = 1'b0;

    cyc(3);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
